fpga2_receiver: RTL

FPGA2_RECEIVER -- requirements
Module: fpga2_receiver

---
 rtl/fpga2_receiver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fpga2_receiver.sv
// fpga2_receiver: receive side of an FPGA-to-FPGA frame link.
// The sender raises req_in and streams valid_in/data_in words while rdy_out is
// high, then marks the end of the frame with a 3-cycle send_done_in pulse. A
// frame with exactly expected_count words, no overrun and no downstream
// overflow is ACKed. Any other frame is NAKed, and downstream is told to drop
// the words it already wrote.
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   req_in, valid_in, data_in   sender request and data stream
//   send_done_in                end-of-frame marker (stretched, edge detected)
//   expected_count              words per frame, latched at frame start
//   prog_full_i                 downstream almost full
//   rdy_out, ack_out            handshake back to sender
//   wr_en_o, wr_data_o          downstream write port (1-cycle latency)
//   discard_o, done_o, err_o    1-cycle frame event pulses
//   rx_count_o, retry_count_o   words accepted / saturating reject count
// All outputs are registered.
module fpga2_receiver #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int NAK_HOLD       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  input  logic        send_done_in,
  input  logic [9:0]  expected_count,
  input  logic        prog_full_i,
  output logic        rdy_out,
  output logic        ack_out,
  output logic        wr_en_o,
  output logic [31:0] wr_data_o,
  output logic        discard_o,
  output logic        done_o,
  output logic        err_o,
  output logic [9:0]  rx_count_o,
  output logic [7:0]  retry_count_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(NAK_HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVE,
    S_CHECK,
    S_ACK,
    S_NAK
  } state_t;

  state_t        state, state_d;
  logic [9:0]    exp_cnt, exp_cnt_d;
  logic [9:0]    rx_cnt_d;
  logic          overrun, overrun_d;
  logic          overflow, overflow_d;
  logic [TW-1:0] timer, timer_d;
  logic [NW-1:0] nak_cnt, nak_cnt_d;
  logic          sd_prev;
  logic          sd_edge;
  logic          enter_nak;
  logic          rdy_d, ack_d, wr_en_d, discard_d, done_d, err_d;
  logic [31:0]   wr_data_d;
  logic [7:0]    retry_d;

  // Only the first cycle of the stretched end-of-frame marker is an event.
  assign sd_edge = send_done_in & ~sd_prev;

  always_comb begin
    state_d    = state;
    exp_cnt_d  = exp_cnt;
    rx_cnt_d   = rx_count_o;
    overrun_d  = overrun;
    overflow_d = overflow;
    timer_d    = timer;
    nak_cnt_d  = nak_cnt;
    wr_data_d  = wr_data_o;
    retry_d    = retry_count_o;
    wr_en_d    = 1'b0;
    discard_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    enter_nak  = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_in && !prog_full_i) begin
          exp_cnt_d  = expected_count;
          rx_cnt_d   = '0;
          overrun_d  = 1'b0;
          overflow_d = 1'b0;
          timer_d    = '0;
          state_d    = S_RECEIVE;
        end
      end

      S_RECEIVE: begin
        // A word arriving together with the end-of-frame edge still counts,
        // because the CHECK decision is made one cycle later.
        if (valid_in) begin
          if (rx_count_o >= exp_cnt) overrun_d  = 1'b1;
          if (prog_full_i)           overflow_d = 1'b1;
          if (!prog_full_i && (rx_count_o < exp_cnt)) begin
            wr_en_d   = 1'b1;
            wr_data_d = data_in;
            rx_cnt_d  = rx_count_o + 10'd1;
          end
        end
        timer_d = (valid_in || sd_edge) ? '0 : timer + TW'(1);
        if (!req_in) begin
          enter_nak = 1'b1;
        end else if (sd_edge) begin
          state_d = S_CHECK;
        end else if (!valid_in && (timer == TW'(TIMEOUT_CYCLES - 1))) begin
          enter_nak = 1'b1;
        end
      end

      S_CHECK: begin
        if ((rx_count_o == exp_cnt) && !overrun && !overflow) state_d = S_ACK;
        else                                                 enter_nak = 1'b1;
      end

      S_ACK: begin
        if (!req_in) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_NAK: begin
        // NAK lasts NAK_HOLD-1 cycles; the IDLE cycle that follows completes
        // the NAK_HOLD cycles of rdy_out low seen by a retrying sender.
        if (nak_cnt == NW'(NAK_HOLD - 2)) state_d = S_IDLE;
        else                              nak_cnt_d = nak_cnt + NW'(1);
      end

      default: state_d = S_IDLE;
    endcase

    if (enter_nak) begin
      state_d   = S_NAK;
      nak_cnt_d = '0;
      discard_d = 1'b1;
      err_d     = 1'b1;
      if (retry_count_o != 8'hFF) retry_d = retry_count_o + 8'd1;
    end

    rdy_d = (state_d == S_RECEIVE) || (state_d == S_CHECK);
    ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      exp_cnt       <= '0;
      rx_count_o    <= '0;
      overrun       <= 1'b0;
      overflow      <= 1'b0;
      timer         <= '0;
      nak_cnt       <= '0;
      sd_prev       <= 1'b0;
      rdy_out       <= 1'b0;
      ack_out       <= 1'b0;
      wr_en_o       <= 1'b0;
      wr_data_o     <= '0;
      discard_o     <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      retry_count_o <= '0;
    end else begin
      state         <= state_d;
      exp_cnt       <= exp_cnt_d;
      rx_count_o    <= rx_cnt_d;
      overrun       <= overrun_d;
      overflow      <= overflow_d;
      timer         <= timer_d;
      nak_cnt       <= nak_cnt_d;
      sd_prev       <= send_done_in;
      rdy_out       <= rdy_d;
      ack_out       <= ack_d;
      wr_en_o       <= wr_en_d;
      wr_data_o     <= wr_data_d;
      discard_o     <= discard_d;
      done_o        <= done_d;
      err_o         <= err_d;
      retry_count_o <= retry_d;
    end
  end

endmodule
